ordinatore_ctrl: RTL and testbench

//   Sequential sorter controller: accepts N unsigned W-bit words serially, sorts them

---
 rtl/ordinatore_ctrl_pkg.sv | 8 +
 rtl/ordinatore_ctrl_comparatore.sv | 14 +
 rtl/ordinatore_ctrl.sv | 80 ++++++++
 tb/tb_ordinatore_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/ordinatore_ctrl_pkg.sv
// ordinatore_ctrl_pkg: state encoding shared by the sorter controller.
package ordinatore_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_SORT = 2'd1,
      ST_OUT  = 2'd2
   } state_t;
endpackage

// File: rtl/ordinatore_ctrl_comparatore.sv
// comparatore_w: unsigned magnitude comparator, exactly one of gt/eq/lt is high.
module comparatore_w #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_gt,
   output logic         o_eq,
   output logic         o_lt
);
   assign o_gt = i_a > i_b;
   assign o_eq = i_a == i_b;
   assign o_lt = i_a < i_b;
endmodule

// File: rtl/ordinatore_ctrl.sv
// ordinatore_ctrl: serial load, bubble sort on one shared comparator, ascending stream-out.
module ordinatore_ctrl
   import ordinatore_ctrl_pkg::*;
#(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         done
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST   = IW'(N - 1);
   localparam logic [IW-1:0] J_LAST = IW'(N - 2);
   state_t        r_state, w_next;
   logic [W-1:0]  r_buf [N];
   logic [IW-1:0] r_wr, r_rd, r_j, r_pass, w_j1;
   logic          r_swapped, r_done;
   logic          w_gt, w_eq, w_lt, w_swap, w_any, w_in_xfer, w_out_xfer, w_sort_end;
   comparatore_w #(.W(W)) u_cmp (
      .i_a  (r_buf[r_j]),
      .i_b  (r_buf[w_j1]),
      .o_gt (w_gt),
      .o_eq (w_eq),
      .o_lt (w_lt)
   );
   always_comb begin
      w_j1       = r_j + IW'(1);
      w_in_xfer  = r_state == ST_LOAD && in_valid;
      w_out_xfer = r_state == ST_OUT && out_ready;
      w_swap     = w_gt & ~(w_eq | w_lt);
      w_any      = r_swapped | w_swap;
      // a pass ends sorted when it saw no swap, or after the N-1 passes bubble sort needs
      w_sort_end = r_state == ST_SORT && r_j == J_LAST && (!w_any || r_pass == J_LAST);
      w_next     = (w_in_xfer && r_wr == LAST)  ? ST_SORT :
                   w_sort_end                   ? ST_OUT  :
                   (w_out_xfer && r_rd == LAST) ? ST_LOAD : r_state;
      in_ready   = r_state == ST_LOAD;
      busy       = r_state != ST_LOAD;
      out_valid  = r_state == ST_OUT;
      out_data   = r_state == ST_OUT ? r_buf[r_rd] : '0;
      done       = r_done;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_LOAD;
         r_wr      <= '0;
         r_rd      <= '0;
         r_j       <= '0;
         r_pass    <= '0;
         r_swapped <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < N; i++) r_buf[i] <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_sort_end;
         if (w_in_xfer) begin
            r_buf[r_wr] <= in_data;
            r_wr        <= r_wr == LAST ? '0 : r_wr + IW'(1);
         end
         if (r_state == ST_SORT) begin
            if (w_swap) begin
               r_buf[r_j]  <= r_buf[w_j1];
               r_buf[w_j1] <= r_buf[r_j];
            end
            r_j       <= r_j == J_LAST ? '0 : w_j1;
            r_pass    <= r_j != J_LAST ? r_pass : w_sort_end ? '0 : r_pass + IW'(1);
            r_swapped <= r_j != J_LAST && w_any;
         end
         if (w_out_xfer) r_rd <= r_rd == LAST ? '0 : r_rd + IW'(1);
      end
   end
endmodule

// File: tb/tb_ordinatore_ctrl.sv
// tb_ordinatore_ctrl: directed batches with hand-computed sort results and compare counts.
module tb_ordinatore_ctrl;
   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, in_ready, out_valid, busy, done;
   logic [3:0] in_data, out_data;
   int         n_chk = 0;
   int         n_err = 0;
   ordinatore_ctrl #(.W(4), .N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic load4(input logic [3:0] a, b, c, d, input bit keep_valid);
      logic [3:0] v [4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = v[i];
         @(negedge clk);
      end
      in_valid = keep_valid;
      in_data  = 4'd7;
   endtask
   task automatic wait_sort(input string tag, input int exp_cmp);
      int cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, "_compares"}, cnt, exp_cmp);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_in_ready"}, in_ready, 0);
   endtask
   task automatic expect_out(input string tag, input logic [3:0] a, b, c, d);
      logic [3:0] v [4];
      v = '{a, b, c, d};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_valid%0d", tag, i), out_valid, 1);
         chk($sformatf("%s_data%0d", tag, i), out_data, v[i]);
         if (i == 1) chk({tag, "_done_pulse"}, done, 0);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk({tag, "_back_in_ready"}, in_ready, 1);
      chk({tag, "_back_out_valid"}, out_valid, 0);
      chk({tag, "_back_busy"}, busy, 0);
   endtask
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_data", out_data, 0);
      // out_ready while idle must be ignored
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      load4(4'd3, 4'd1, 4'd2, 4'd0, 1'b0);
      wait_sort("t1", 9);
      expect_out("t1", 4'd0, 4'd1, 4'd2, 4'd3);
      load4(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
      wait_sort("t2", 3);
      expect_out("t2", 4'd0, 4'd1, 4'd2, 4'd3);
      load4(4'd15, 4'd15, 4'd15, 4'd15, 1'b0);
      wait_sort("t3", 3);
      expect_out("t3", 4'd15, 4'd15, 4'd15, 4'd15);
      // in_valid stays high with in_data=7 through SORT and OUT
      load4(4'd15, 4'd14, 4'd13, 4'd0, 1'b1);
      wait_sort("t4", 9);
      expect_out("t4", 4'd0, 4'd13, 4'd14, 4'd15);
      in_valid = 1'b0;
      load4(4'd3, 4'd1, 4'd2, 4'd0, 1'b0);
      wait_sort("t5", 9);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_hold_valid%0d", i), out_valid, 1);
         chk($sformatf("t5_hold_data%0d", i), out_data, 0);
         @(negedge clk);
      end
      expect_out("t5", 4'd0, 4'd1, 4'd2, 4'd3);
      load4(4'd3, 4'd1, 4'd2, 4'd0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t6_mid_sort_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      load4(4'd2, 4'd0, 4'd3, 4'd1, 1'b0);
      wait_sort("t6", 9);
      expect_out("t6", 4'd0, 4'd1, 4'd2, 4'd3);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
